// File: rtl/clock24_pkg.sv
// ---------------------------------------------------------------------------
// clock24_pkg
// Shared definitions for the 24-hour time-of-day counter.
//   bcd2_t    : two-digit packed BCD value, tens in [7:4], units in [3:0]
//   SEC_MAX   : last valid seconds value (59)
//   MIN_MAX   : last valid minutes value (59)
//   HOUR_MAX  : last valid hours value (23)
//   bcd_next  : next value of a two-digit BCD counter that wraps at a maximum
// ---------------------------------------------------------------------------
package clock24_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // For valid BCD, the digit ordering matches the binary ordering, so a
  // plain magnitude compare against the maximum finds the wrap point.
  // Any corrupted value (digit above 9 or past the maximum) falls back to 00
  // so the counter always recovers on its next update.
  function automatic bcd2_t bcd_next(input bcd2_t v, input bcd2_t max);
    bcd2_t n;
    if ((v >= max) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9)) begin
      n = '0;
    end else if (v[3:0] == 4'd9) begin
      n = {v[7:4] + 4'd1, 4'd0};
    end else begin
      n = {v[7:4], v[3:0] + 4'd1};
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter that counts 00..MAX and wraps to 00.
// Ports:
//   CLK    : clock, rising edge
//   RST_N  : synchronous active-low reset, clears the count
//   inc    : manual increment pulse (adjust button), never produces a carry
//   clr    : clear to 00, wins over inc and cin, never produces a carry
//   cin    : carry from the next lower stage
//   cout   : combinational carry to the next higher stage, so the higher
//            stage updates on the same edge as this one
//   value  : registered count
// ---------------------------------------------------------------------------
module bcd_mod_counter
  import clock24_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  inc,
  input  logic  clr,
  input  logic  cin,
  output logic  cout,
  output bcd2_t value
);

  logic step;

  // A manual increment and a carry arriving together advance the count by
  // one only: the manual pulse absorbs the carry.
  assign step = inc | cin;

  // Only a genuine carry-driven rollover propagates upward; a manual
  // increment through the maximum or a clear stays local to this stage.
  assign cout = cin & ~inc & ~clr & (value == MAX);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (step) begin
      value <= bcd_next(value, MAX);
    end
  end

endmodule

// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter
// 24-hour time-of-day counter (HH:MM:SS in BCD) driven by a prescaled clock.
// CLK_HZ must be a multiple of 4 and at least 4.
// Ports:
//   CLK      : clock, all state updates on the rising edge
//   RST_N    : synchronous active-low reset, overrides every other input
//   SECCLR   : clears seconds and restarts the current second
//   MININC   : increments minutes (wraps 59 -> 00, no hour carry)
//   HOURINC  : increments hours (wraps 23 -> 00, no day carry)
//   SEC      : seconds, BCD 00-59
//   MIN      : minutes, BCD 00-59
//   HOUR     : hours, BCD 00-23
//   SIG2HZ   : 2 Hz square wave, 50% duty
//   TICK1HZ  : one-cycle pulse per second
//   DAYCARRY : one-cycle pulse when the time rolls 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module time_counter
  import clock24_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SECCLR,
  input  logic       MININC,
  input  logic       HOURINC,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
  output logic [7:0] HOUR,
  output logic       SIG2HZ,
  output logic       TICK1HZ,
  output logic       DAYCARRY
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  // Prescaler values at which the 2 Hz wave toggles (every quarter second).
  localparam logic [CW-1:0] Q1   = CW'(CLK_HZ / 4 - 1);
  localparam logic [CW-1:0] Q2   = CW'(CLK_HZ / 2 - 1);
  localparam logic [CW-1:0] Q3   = CW'(3 * (CLK_HZ / 4) - 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] presc;
  logic          wrap;
  logic          secCarry;
  logic          minCarry;
  logic          hourCarry;

  assign wrap = (presc == LAST);

  // Prescaler, 2 Hz wave and the registered pulse outputs. A seconds clear
  // restarts the prescaler so the next tick is a full second away, and a
  // clear landing on the wrap cycle swallows that tick entirely.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc    <= '0;
      SIG2HZ   <= 1'b0;
      TICK1HZ  <= 1'b0;
      DAYCARRY <= 1'b0;
    end else begin
      if (SECCLR || wrap) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
      if ((presc == Q1) || (presc == Q2) || (presc == Q3) || (presc == LAST)) begin
        SIG2HZ <= ~SIG2HZ;
      end
      TICK1HZ  <= wrap & ~SECCLR;
      DAYCARRY <= hourCarry;
    end
  end

  // Seconds advance only on the prescaler wrap; the clear input inside the
  // counter already blocks both the increment and the minute carry.
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (1'b0),
    .clr   (SECCLR),
    .cin   (wrap),
    .cout  (secCarry),
    .value (SEC)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (MININC),
    .clr   (1'b0),
    .cin   (secCarry),
    .cout  (minCarry),
    .value (MIN)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (HOURINC),
    .clr   (1'b0),
    .cin   (minCarry),
    .cout  (hourCarry),
    .value (HOUR)
  );

endmodule

// File: tb/tb_time_counter.sv
// ---------------------------------------------------------------------------
// tb_time_counter
// Directed bench for time_counter with CLK_HZ = 8 (one second = 8 cycles).
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, so every check sees the state produced by the edge just passed.
// ---------------------------------------------------------------------------
module tb_time_counter;

  logic       clk;
  logic       rstN;
  logic       secClr;
  logic       minInc;
  logic       hourInc;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic       sig2hz;
  logic       tick1hz;
  logic       dayCarry;

  int checkCount = 0;
  int errorCount = 0;

  time_counter #(.CLK_HZ(8)) dut (
    .CLK      (clk),
    .RST_N    (rstN),
    .SECCLR   (secClr),
    .MININC   (minInc),
    .HOURINC  (hourInc),
    .SEC      (sec),
    .MIN      (min),
    .HOUR     (hour),
    .SIG2HZ   (sig2hz),
    .TICK1HZ  (tick1hz),
    .DAYCARRY (dayCarry)
  );

  // 10 ns clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log misses.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance n rising edges, ending 1 ns after the last one.
  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the adjust inputs for n cycles, then drop them.
  task automatic applyStimulus(input logic sc, input logic mi, input logic hi,
                               input int n);
    secClr  = sc;
    minInc  = mi;
    hourInc = hi;
    runCycles(n);
    secClr  = 1'b0;
    minInc  = 1'b0;
    hourInc = 1'b0;
  endtask

  initial begin
    rstN    = 1'b0;
    secClr  = 1'b0;
    minInc  = 1'b0;
    hourInc = 1'b0;

    // Reset state
    runCycles(2);
    checkOutput("rst_sec",  32'(sec),      32'h00);
    checkOutput("rst_min",  32'(min),      32'h00);
    checkOutput("rst_hour", 32'(hour),     32'h00);
    checkOutput("rst_sig",  32'(sig2hz),   32'd0);
    checkOutput("rst_tick", 32'(tick1hz),  32'd0);
    checkOutput("rst_day",  32'(dayCarry), 32'd0);

    // First second after release: tick on the 8th edge, 2 Hz toggles every 2
    rstN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      runCycles(1);
      checkOutput($sformatf("sig2hz_c%0d", i), 32'(sig2hz), 32'((i / 2) % 2));
      checkOutput($sformatf("tick_c%0d", i), 32'(tick1hz), 32'(i == 8));
    end
    checkOutput("first_sec", 32'(sec), 32'h01);
    runCycles(1);
    checkOutput("tick_drop", 32'(tick1hz), 32'd0);

    // Seconds clear landing on the wrap cycle at 59
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    runCycles(59 * 8 + 7);
    checkOutput("pre_clr_sec", 32'(sec), 32'h59);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("clr_sec",  32'(sec),     32'h00);
    checkOutput("clr_min",  32'(min),     32'h00);
    checkOutput("clr_tick", 32'(tick1hz), 32'd0);
    runCycles(7);
    checkOutput("clr_notick7", 32'(tick1hz), 32'd0);
    checkOutput("clr_sec7",    32'(sec),     32'h00);
    runCycles(1);
    checkOutput("clr_tick8", 32'(tick1hz), 32'd1);
    checkOutput("clr_sec8",  32'(sec),     32'h01);

    // Minute increment absorbing a seconds carry, then held hour increment
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    checkOutput("preset_min10", 32'(min), 32'h10);
    checkOutput("preset_sec0",  32'(sec), 32'h00);
    runCycles(59 * 8 + 7);
    checkOutput("absorb_pre_sec", 32'(sec), 32'h59);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("absorb_sec",  32'(sec),  32'h00);
    checkOutput("absorb_min",  32'(min),  32'h11);
    checkOutput("absorb_hour", 32'(hour), 32'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    checkOutput("hold_hour3", 32'(hour), 32'h03);

    // Manual minute wrap does not carry, manual hour wrap gives no day carry
    applyStimulus(1'b1, 1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 46);
    checkOutput("preset_min59", 32'(min),  32'h59);
    checkOutput("preset_hour5", 32'(hour), 32'h05);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("minwrap_min",  32'(min),  32'h00);
    checkOutput("minwrap_hour", 32'(hour), 32'h05);
    applyStimulus(1'b1, 1'b0, 1'b1, 18);
    checkOutput("preset_hour23", 32'(hour), 32'h23);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("hourwrap_hour", 32'(hour),     32'h00);
    checkOutput("hourwrap_day",  32'(dayCarry), 32'd0);
    runCycles(1);
    checkOutput("hourwrap_day2", 32'(dayCarry), 32'd0);

    // Full-day rollover from 23:59:59
    applyStimulus(1'b1, 1'b1, 1'b1, 23);
    applyStimulus(1'b1, 1'b1, 1'b0, 36);
    runCycles(59 * 8 + 7);
    checkOutput("day_pre_sec",  32'(sec),      32'h59);
    checkOutput("day_pre_min",  32'(min),      32'h59);
    checkOutput("day_pre_hour", 32'(hour),     32'h23);
    checkOutput("day_pre_dc",   32'(dayCarry), 32'd0);
    runCycles(1);
    checkOutput("day_sec",  32'(sec),      32'h00);
    checkOutput("day_min",  32'(min),      32'h00);
    checkOutput("day_hour", 32'(hour),     32'h00);
    checkOutput("day_dc",   32'(dayCarry), 32'd1);
    checkOutput("day_tick", 32'(tick1hz),  32'd1);
    runCycles(1);
    checkOutput("day_dc_drop", 32'(dayCarry), 32'd0);

    // Reset at 12:34:56 together with a minute increment
    applyStimulus(1'b1, 1'b1, 1'b1, 12);
    applyStimulus(1'b1, 1'b1, 1'b0, 22);
    runCycles(56 * 8);
    checkOutput("pre_rst_sec",  32'(sec),  32'h56);
    checkOutput("pre_rst_min",  32'(min),  32'h34);
    checkOutput("pre_rst_hour", 32'(hour), 32'h12);
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    rstN = 1'b1;
    checkOutput("mid_rst_sec",  32'(sec),      32'h00);
    checkOutput("mid_rst_min",  32'(min),      32'h00);
    checkOutput("mid_rst_hour", 32'(hour),     32'h00);
    checkOutput("mid_rst_sig",  32'(sig2hz),   32'd0);
    checkOutput("mid_rst_tick", 32'(tick1hz),  32'd0);
    checkOutput("mid_rst_dc",   32'(dayCarry), 32'd0);
    runCycles(7);
    checkOutput("rel_notick7", 32'(tick1hz), 32'd0);
    runCycles(1);
    checkOutput("rel_tick8", 32'(tick1hz), 32'd1);
    checkOutput("rel_sec8",  32'(sec),     32'h01);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
